// File: rtl/uart_rx_frame_sequencer.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_sequencer
//
// Receive-side frame sequencer. Oversamples the synchronized serial line and
// walks each frame through start, data, parity and stop phases. The captured
// fields and a one-cycle recieved_flag go to the external error checker. The
// data byte and the checker's error flags are then latched into a one-entry
// valid/ready output buffer.
//
// Ports
//   clk, rst_n     single clock, asynchronous active-low reset
//   tick           oversample enable (one clk wide), OVERSAMPLE ticks per bit
//   rx             serial line, already synchronized, idles high
//   parity_type    01 odd, 10 even, 00/11 no parity bit in the frame
//   start_bit      mid-bit sample of the start bit          (to checker)
//   raw_data       data byte, LSB first on the line         (to checker)
//   parity_bit     sampled parity bit, 0 when no parity     (to checker)
//   stop_bit       sampled stop bit                         (to checker)
//   recieved_flag  one-cycle pulse, fields complete and stable
//   error_flag     {stop_err, start_err, parity_err} from checker (comb.)
//   rx_data        buffered byte
//   rx_error       buffered error flags for that byte
//   rx_valid       buffer holds a frame
//   rx_ready       consumer accepts the buffered frame
//   overrun        one-cycle pulse, a completed frame was dropped
//   busy           FSM is not idle
//   dbg_state      current FSM state encoding, for observation only
//
// Output handshake: a frame moves to the consumer on every rising clk edge
// where rx_valid and rx_ready are both high. rx_valid stays high, with
// rx_data/rx_error stable, until that edge. rx_ready may toggle freely and
// has no effect while rx_valid is low.
// -----------------------------------------------------------------------------
module uart_rx_frame_sequencer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       rx,
    input  logic [1:0] parity_type,
    output logic       start_bit,
    output logic [7:0] raw_data,
    output logic       parity_bit,
    output logic       stop_bit,
    output logic       recieved_flag,
    input  logic [2:0] error_flag,
    output logic [7:0] rx_data,
    output logic [2:0] rx_error,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overrun,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int CW = $clog2(OVERSAMPLE);
    // Counter values on which a sample is taken: half a bit after the
    // detection tick for the start bit, then once per full bit period.
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            armed;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic            par_en;

    logic            start_det;
    logic            half_hit;
    logic            bit_hit;
    logic            accept;
    logic            load_buf;

    assign dbg_state = state;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and combinational outputs
    // -------------------------------------------------------------------------
    always_comb begin
        next_state    = state;
        start_det     = 1'b0;
        recieved_flag = 1'b0;
        load_buf      = 1'b0;
        overrun       = 1'b0;
        busy          = (state != S_IDLE);
        accept        = rx_valid && rx_ready;
        half_hit      = tick && (cnt == HALF_LAST);
        bit_hit       = tick && (cnt == BIT_LAST);

        case (state)
            S_IDLE: begin
                // A falling edge only counts once the line has been seen high
                // on a tick since the last frame; a held-low line stays quiet.
                if (tick && armed && !rx) begin
                    start_det  = 1'b1;
                    next_state = S_START;
                end
            end
            S_START: begin
                if (half_hit) begin
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_hit && (idx == 3'd7)) begin
                    next_state = par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_hit) begin
                    next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_hit) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                // Single cycle regardless of tick; the checker's answer is
                // taken in this cycle. A consumer handshake in this same cycle
                // frees the buffer for the new frame.
                recieved_flag = 1'b1;
                next_state    = S_IDLE;
                load_buf      = !rx_valid || accept;
                overrun       = rx_valid && !rx_ready;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Arming, oversample counter, bit index and frame parity mode
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed  <= 1'b0;
            cnt    <= '0;
            idx    <= 3'd0;
            par_en <= 1'b0;
        end else begin
            if (state != S_IDLE || start_det) begin
                armed <= 1'b0;
            end else if (tick && rx) begin
                armed <= 1'b1;
            end

            // parity_type is only looked at when a frame starts, so a change
            // mid-frame cannot alter the frame length.
            if (start_det) begin
                par_en <= (parity_type == 2'b01) || (parity_type == 2'b10);
            end

            case (state)
                S_START: begin
                    if (tick) begin
                        cnt <= half_hit ? '0 : cnt + CW'(1);
                    end
                    if (half_hit) begin
                        idx <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        cnt <= bit_hit ? '0 : cnt + CW'(1);
                    end
                    if (bit_hit) begin
                        idx <= idx + 3'd1;
                    end
                end
                S_PARITY, S_STOP: begin
                    if (tick) begin
                        cnt <= bit_hit ? '0 : cnt + CW'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Captured frame fields; each holds until the next frame overwrites it
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_bit  <= 1'b0;
            raw_data   <= 8'h00;
            parity_bit <= 1'b0;
            stop_bit   <= 1'b0;
        end else begin
            case (state)
                S_START: begin
                    if (half_hit) begin
                        start_bit <= rx;
                    end
                end
                S_DATA: begin
                    if (bit_hit) begin
                        raw_data[idx] <= rx;
                        // Moving straight to STOP: a frame without parity
                        // must not show the previous frame's parity bit.
                        if ((idx == 3'd7) && !par_en) begin
                            parity_bit <= 1'b0;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_hit) begin
                        parity_bit <= rx;
                    end
                end
                S_STOP: begin
                    if (bit_hit) begin
                        stop_bit <= rx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // One-entry output buffer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= 8'h00;
            rx_error <= 3'b000;
            rx_valid <= 1'b0;
        end else begin
            if (load_buf) begin
                rx_data  <= raw_data;
                rx_error <= error_flag;
                rx_valid <= 1'b1;
            end else if (accept) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_frame_sequencer.md
# uart_rx_frame_sequencer

Receive-side frame sequencer for the UART. It oversamples the synchronized serial input and walks a frame through the start, data, parity and stop phases. It drives the captured fields and a one-cycle `recieved_flag` into the `Error_check` block, then latches the data byte and the returned 3-bit error flags into a one-entry valid/ready output buffer. It sits between the baud/oversample tick generator and the receive host interface.

## Interface
- `OVERSAMPLE`, default 16: ticks per bit. Must be even and ≥ 4.
- `clk`  in  1  Single clock for all state.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `tick`  in  1  Oversample enable, one `clk` cycle wide.
- `rx`  in  1  Serial line, already synchronized to `clk`. Idle level is 1.
- `parity_type`  in  2  01 = odd, 10 = even, 00/11 = no parity bit in the frame.
- `start_bit`  out  1  Mid-bit sample of the start bit; goes to the checker.
- `raw_data`  out  8  Data bits, LSB first on the line; goes to the checker.
- `parity_bit`  out  1  Sampled parity bit. Forced to 0 when there is no parity.
- `stop_bit`  out  1  Sampled stop bit; goes to the checker.
- `recieved_flag`  out  1  One-cycle pulse: frame complete and fields stable.
- `error_flag`  in  3  From the checker, combinational: {stop_err, start_err, parity_err}.
- `rx_data`  out  8  Buffered byte.
- `rx_error`  out  3  Buffered error flags for that byte.
- `rx_valid`  out  1  Output buffer holds a frame.
- `rx_ready`  in  1  Consumer accepts the frame.
- `overrun`  out  1  One-cycle pulse: a completed frame was dropped.
- `busy`  out  1  High whenever the FSM is not in IDLE.

## Operation
FSM states: IDLE, START, DATA, PARITY, STOP, DONE. All transitions except DONE→IDLE happen only on a `tick` cycle. `cnt` is the oversample counter; `idx` is the 3-bit data bit index.

- **IDLE**
  - An `armed` flag sets on any tick with `rx`=1.
  - On a tick with `armed`=1 and `rx`=0: go to START with `cnt`=0.
  - `armed` clears on leaving IDLE.
- **START**
  - Each tick increments `cnt`.
  - At the tick where `cnt`==OVERSAMPLE/2−1: `start_bit`←`rx`, `cnt`←0, `idx`←0, go to DATA.
  - There is no false-start rejection. A high sample is passed on and reported by the checker as a start error.
- **DATA**
  - At the tick where `cnt`==OVERSAMPLE−1: `raw_data[idx]`←`rx`, `cnt`←0, `idx`++.
  - After `idx`=7: go to PARITY if `parity_type` is 01 or 10, otherwise go to STOP.
- **PARITY**
  - Same sampling rule; `parity_bit`←`rx`, then go to STOP.
  - When the frame has no parity, `parity_bit` is cleared to 0 on entry to STOP.
- **STOP**
  - Same sampling rule; `stop_bit`←`rx`, then go to DONE.
- **DONE**
  - Lasts exactly one `clk` cycle, independent of `tick`.
  - `recieved_flag`=1 in this cycle.
  - `error_flag` is sampled in this same cycle, then the FSM returns to IDLE.

Rules that hold across states:
- `parity_type` is sampled once, on the IDLE→START transition. Changes mid-frame have no effect on the current frame.
- Captured fields (`start_bit`, `raw_data`, `parity_bit`, `stop_bit`) hold their values until overwritten by the next frame.
- `busy` = (state != IDLE).

Output buffer, evaluated in the DONE cycle:
- If `rx_valid`=0, or `rx_valid`&&`rx_ready` in that cycle: load `rx_data`←`raw_data` and `rx_error`←`error_flag`, and `rx_valid`←1.
- Otherwise the frame is discarded, `overrun` pulses for one cycle, and the buffer keeps its old contents.
- Outside DONE, `rx_valid`&&`rx_ready` clears `rx_valid` on the next edge.

Reset (asynchronous, any state):
- State→IDLE; `armed`, `cnt`, `idx`→0.
- All outputs→0: `start_bit`, `raw_data`, `parity_bit`, `stop_bit`, `recieved_flag`, `rx_data`, `rx_error`, `rx_valid`, `overrun`, `busy`.
- A frame in progress is aborted. No `recieved_flag` or `rx_valid` is produced for it.

## Timing
- The detection tick is tick 0. The start bit is sampled on tick OVERSAMPLE/2; each later bit is sampled exactly OVERSAMPLE ticks after the previous one.
- The stop bit is sampled on a tick edge. `recieved_flag` is high in the following `clk` cycle (DONE).
- `rx_valid` and `rx_data`/`rx_error` update on the edge ending DONE, one cycle after `recieved_flag`.
- The minimum frame-to-frame spacing is governed by `armed`: after DONE, at least one tick with `rx`=1 is needed before the next start can be detected. A line held low (break) produces exactly one frame, followed by silence.
- `tick` and `rx_ready` may be asserted in any cycle, including DONE. The DONE-cycle rules above take priority over the handshake.
- Frame length in ticks: OVERSAMPLE/2 + OVERSAMPLE·(9 + parity) from the detection tick to the stop sample.

## Test plan
- **8N1, data 0xA5:** OVERSAMPLE=16, `parity_type`=00, `tick` every clk, `rx_ready`=1, sent as a clean frame → exactly one `recieved_flag` pulse, 8+16·9 ticks after detection; `rx_data`=0xA5, `rx_error`=000, `rx_valid` high for 1 cycle.
- **Even parity, data 0x03:** `parity_type`=10 with parity bit 0 → `rx_error`=000. Same frame with parity bit 1 → `rx_error`=001.
- **Stop bit 0, then line held low:** frame sent with stop bit 0 and `rx` kept low afterwards → `rx_error`=100, one frame only, `busy`=0 until `rx` returns high and a new start is sent.
- **Start glitch:** `rx` low for 4 ticks then high for the rest of the frame → `start_bit`=1, `raw_data`=0xFF, `rx_error`=010 (8N1, stop bit 1).
- **Overrun:** `rx_ready`=0, two frames 0x11 then 0x22 → `overrun` pulses in the second DONE cycle; `rx_data` stays 0x11. Raising `rx_ready` clears `rx_valid` on the next cycle.
- **Reset mid-frame:** `rst_n` pulsed low during DATA bit 4 → all outputs 0 immediately and no `recieved_flag`. The next clean 0x5A frame is received with `rx_error`=000.
